// File: rtl/breath_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | breath_pkg : mode encodings and colour table for breath_sequencer   |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
package breath_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO = 2'b00,
        MODE_HOLD = 2'b01,
        MODE_OFF  = 2'b10
    } mode_e;

    localparam int NUM_COLORS = 7;

    // Entry k sits at packed index k: 001, 010, 100, 011, 110, 101, 111.
    localparam logic [NUM_COLORS-1:0][2:0] COLOR_TABLE = {
        3'b111, 3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001
    };

    localparam logic [2:0] RST_RGB = 3'b001;

    function automatic logic [2:0] color_lookup(input logic [2:0] idx);
        logic [2:0] rgb;
        rgb = 3'b000;
        if (idx < 3'(NUM_COLORS)) begin
            rgb = COLOR_TABLE[idx];
        end
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/breath_sequencer_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-flop sync plus counter debouncer, press pulse out  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 156250,
    parameter int CNT_W           = 18
) (
    input  logic clk_div_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level, so any agreeing sample restarts the stability window.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == c_cnt_max) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_div_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/breath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | breath_sequencer : mode FSM and colour sequencing for the breather  |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module breath_sequencer
    import breath_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 156250,
    parameter int CNT_W           = 18
) (
    input  logic       clk_div_i,
    input  logic       rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_next_i,
    input  logic       breath_clk_i,
    output logic [2:0] rgb_o,
    output logic [1:0] mode_o,
    output logic [2:0] color_idx_o,
    output logic       period_end_o
);

    logic       mode_press, next_press;
    logic       mode_level_unused, next_level_unused;
    logic       advance;

    logic       bsync1_q, bsync1_d;
    logic       bsync2_q, bsync2_d;
    logic       bprev_q,  bprev_d;
    logic       period_end_q, period_end_d;
    mode_e      mode_q, mode_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] rgb_q, rgb_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbn_mode (
        .clk_div_i (clk_div_i),
        .rst_i     (rst_i),
        .btn_i     (btn_mode_i),
        .level_o   (mode_level_unused),
        .press_o   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dbn_next (
        .clk_div_i (clk_div_i),
        .rst_i     (rst_i),
        .btn_i     (btn_next_i),
        .level_o   (next_level_unused),
        .press_o   (next_press)
    );

    always_comb begin
        bsync1_d     = breath_clk_i;
        bsync2_d     = bsync1_q;
        bprev_d      = bsync2_q;
        period_end_d = bsync2_q & ~bprev_q;

        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                MODE_AUTO: mode_d = MODE_HOLD;
                MODE_HOLD: mode_d = MODE_OFF;
                default:   mode_d = MODE_AUTO;
            endcase
        end

        // Advance is judged against the pre-transition mode.
        advance = ((mode_q == MODE_AUTO) && (period_end_q || next_press)) ||
                  ((mode_q == MODE_HOLD) && next_press);

        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == 3'(NUM_COLORS - 1)) ? 3'd0 : idx_q + 3'd1;
        end

        rgb_d = (mode_d == MODE_OFF) ? 3'b000 : color_lookup(idx_d);
    end

    always_ff @(posedge clk_div_i) begin
        if (rst_i) begin
            bsync1_q     <= 1'b0;
            bsync2_q     <= 1'b0;
            bprev_q      <= 1'b0;
            period_end_q <= 1'b0;
            mode_q       <= MODE_AUTO;
            idx_q        <= 3'd0;
            rgb_q        <= RST_RGB;
        end else begin
            bsync1_q     <= bsync1_d;
            bsync2_q     <= bsync2_d;
            bprev_q      <= bprev_d;
            period_end_q <= period_end_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb_o        = rgb_q;
    assign mode_o       = mode_q;
    assign color_idx_o  = idx_q;
    assign period_end_o = period_end_q;

endmodule
`default_nettype wire

// File: tb/tb_breath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_breath_sequencer : vector table and scoreboard bench             |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_breath_sequencer;

    localparam int c_ev_rise       = 0;
    localparam int c_ev_mode       = 1;
    localparam int c_ev_next       = 2;
    localparam int c_ev_glitch     = 3;
    localparam int c_ev_bounce     = 4;
    localparam int c_ev_combo_next = 5;
    localparam int c_ev_combo_mode = 6;

    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] idx;
        logic [2:0] rgb;
    } exp_t;

    typedef struct {
        int   ev;
        exp_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       breath = 1'b0;
    logic [2:0] rgb;
    logic [1:0] mode;
    logic [2:0] idx;
    logic       pend;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    breath_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk_div_i    (clk),
        .rst_i        (rst),
        .btn_mode_i   (btn_mode),
        .btn_next_i   (btn_next),
        .breath_clk_i (breath),
        .rgb_o        (rgb),
        .mode_o       (mode),
        .color_idx_o  (idx),
        .period_end_o (pend)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int ev, input logic [1:0] m, input logic [2:0] i, input logic [2:0] r);
        vec_t v;
        v.ev       = ev;
        v.exp.mode = m;
        v.exp.idx  = i;
        v.exp.rgb  = r;
        vecs.push_back(v);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rise of the breath marker with the 0,0,1,0 period_end pulse checked per edge.
    task automatic breath_rise();
        @(negedge clk);
        breath = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("period_end edge%0d", k), {31'd0, pend}, {31'd0, (k == 3)});
        end
        wait_neg(16);
        breath = 1'b0;
        wait_neg(20);
    endtask

    task automatic press(input logic is_mode, input int cycles);
        @(negedge clk);
        if (is_mode) btn_mode = 1'b1; else btn_next = 1'b1;
        wait_neg(cycles);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        wait_neg(12);
    endtask

    task automatic bounce();
        logic [6:0] pat;
        pat = 7'b1111101;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            btn_next = pat[k];
        end
        @(negedge clk);
        btn_next = 1'b0;
        wait_neg(12);
    endtask

    // Button raised three cycles ahead of the marker so the debounced press
    // and period_end land on the same cycle.
    task automatic combo(input logic is_mode);
        @(negedge clk);
        if (is_mode) btn_mode = 1'b1; else btn_next = 1'b1;
        wait_neg(3);
        breath = 1'b1;
        wait_neg(10);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        wait_neg(12);
        breath = 1'b0;
        wait_neg(10);
    endtask

    task automatic apply(input int ev);
        case (ev)
            c_ev_rise:       breath_rise();
            c_ev_mode:       press(1'b1, 10);
            c_ev_next:       press(1'b0, 10);
            c_ev_glitch:     press(1'b0, 2);
            c_ev_bounce:     bounce();
            c_ev_combo_next: combo(1'b0);
            default:         combo(1'b1);
        endcase
    endtask

    initial begin
        exp_t e;

        add(c_ev_rise,       2'b00, 3'd1, 3'b010);
        add(c_ev_rise,       2'b00, 3'd2, 3'b100);
        add(c_ev_rise,       2'b00, 3'd3, 3'b011);
        add(c_ev_mode,       2'b01, 3'd3, 3'b011);
        add(c_ev_rise,       2'b01, 3'd3, 3'b011);
        add(c_ev_next,       2'b01, 3'd4, 3'b110);
        add(c_ev_glitch,     2'b01, 3'd4, 3'b110);
        add(c_ev_bounce,     2'b01, 3'd5, 3'b101);
        add(c_ev_mode,       2'b10, 3'd5, 3'b000);
        add(c_ev_rise,       2'b10, 3'd5, 3'b000);
        add(c_ev_next,       2'b10, 3'd5, 3'b000);
        add(c_ev_mode,       2'b00, 3'd5, 3'b101);
        add(c_ev_mode,       2'b01, 3'd5, 3'b101);
        add(c_ev_mode,       2'b10, 3'd5, 3'b000);
        add(c_ev_mode,       2'b00, 3'd5, 3'b101);
        add(c_ev_next,       2'b00, 3'd6, 3'b111);
        add(c_ev_combo_next, 2'b00, 3'd0, 3'b001);
        add(c_ev_combo_mode, 2'b01, 3'd1, 3'b010);
        add(c_ev_next,       2'b01, 3'd2, 3'b100);
        add(c_ev_next,       2'b01, 3'd3, 3'b011);
        add(c_ev_next,       2'b01, 3'd4, 3'b110);

        wait_neg(3);
        rst = 1'b0;
        wait_neg(1);
        check("reset state", {24'd0, mode, idx, rgb, pend}, {24'd0, 2'b00, 3'd0, 3'b001, 1'b0});

        foreach (vecs[n]) begin
            sb_q.push_back(vecs[n].exp);
            apply(vecs[n].ev);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("vector %0d mode/idx/rgb", n), {24'd0, mode, idx, rgb}, {24'd0, e});
        end

        // Reset lands on the cycle before a debounced next press would be accepted.
        @(negedge clk);
        btn_next = 1'b1;
        wait_neg(4);
        rst = 1'b1;
        btn_next = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid-debounce reset", {24'd0, mode, idx, rgb, pend}, {24'd0, 2'b00, 3'd0, 3'b001, 1'b0});
        wait_neg(15);
        check("no press after reset", {24'd0, mode, idx, rgb}, {24'd0, 2'b00, 3'd0, 3'b001});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
